nrisc_pipe_ctrl: RTL
====================

# nrisc_pipe_ctrl

Pipeline sequencer for the 8-bit nRisc processor. It sits between instruction fetch and the decode/demultiplex stage. It owns the program counter and the fetch enable, and presents one validated instruction per cycle to decode. It also resolves taken jumps by flushing, stalls on execute back-pressure, and inserts a bubble on load-use hazards.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value after reset
- FLUSH_CYCLES, 2, bubble cycles after a taken jump; legal range 1..3
- LOAD_OP, 3'b010, opcode (instr[7:5]) of the load instruction that writes reg_a

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instr_in  in  8  instruction from fetch, addressed by pc
- instr_valid  in  1  instr_in is valid this cycle
- jump  in  1  taken jump resolved in execute; one-cycle pulse
- jump_target  in  8  new PC, sampled when jump=1
- ex_busy  in  1  execute cannot accept a new instruction
- pc  out  8  fetch address
- fetch_en  out  1  fetch may present instr_in for pc
- dec_instr  out  8  instruction presented to decode (opcode [7:5], reg_a [4:2], reg_b [1:0])
- dec_valid  out  1  dec_instr is a real instruction; 0 = bubble
- stall  out  1  high in STALL and BUBBLE
- flush  out  1  high in FLUSH

## Operation
- States: RUN, STALL, BUBBLE, FLUSH. Reset state is RUN.
- Reset values: pc=RESET_PC, dec_instr=8'h00, dec_valid=0, stall=0, flush=0, fetch_en=1, flush counter=0.
- fetch_en = (state==RUN), derived from the registered state.
- Hazard (combinational) = dec_valid && dec_instr[7:5]==LOAD_OP && instr_valid && (instr_in[4:2]==dec_instr[4:2] || {1'b0,instr_in[1:0]}==dec_instr[4:2]).
- Per-edge priority: jump > ex_busy > hazard > normal.
- jump=1, in any state:
  - pc<=jump_target, dec_valid<=0.
  - Next state FLUSH, counter<=FLUSH_CYCLES-1.
  - A jump during FLUSH reloads pc and restarts the counter.
- ex_busy=1 (RUN, STALL or BUBBLE): pc, dec_instr and dec_valid hold; next state STALL. STALL returns to RUN on the first edge with ex_busy=0.
- Hazard in RUN:
  - pc holds and instr_in is not accepted; dec_valid<=0 (bubble); next state BUBBLE.
  - BUBBLE always returns to RUN next edge. Fetch re-presents the same instruction, and it is no longer hazarded because dec_valid=0.
- Normal RUN with instr_valid=1: dec_instr<=instr_in, dec_valid<=1, pc<=pc+1. Wraps 8'hFF->8'h00 with no flag.
- RUN with instr_valid=0: pc holds, dec_valid<=0.
- FLUSH:
  - dec_valid stays 0; counter decrements each edge; ex_busy is ignored.
  - At counter==0, next state is STALL if ex_busy=1, else RUN.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. The first accept occurs on the first rising edge after deassertion.

## Timing
- Accept-to-decode latency is 1 cycle: instr_in sampled at edge N appears on dec_instr after edge N.
- Jump at edge N: pc=jump_target after N. fetch_en=0 for FLUSH_CYCLES cycles, then 1. The first instruction from jump_target is accepted at edge N+FLUSH_CYCLES+1.
- Hazard costs exactly one bubble cycle; ex_busy costs one cycle per busy edge.
- pc and dec_* never change while stall=1 due to ex_busy.

## Configuration
- NRISC_HAZARD_EN defined: load-use hazard detection and the BUBBLE state are compiled in, as described above.
- NRISC_HAZARD_EN undefined: hazard is tied to 0 and the BUBBLE state is unreachable. Load-use ordering becomes the compiler's responsibility; all other behaviour is identical.

## Test plan
- Reset, RESET_PC=8'h00, instr_valid=1, instructions 8'h21, 8'h45 -> dec_instr=8'h21 then 8'h45, dec_valid=1, pc=8'h01 then 8'h02.
- pc=8'hFF, instr_valid=1 -> pc=8'h00 next cycle, no stall.
- jump=1, jump_target=8'h40, FLUSH_CYCLES=2 -> pc=8'h40, flush=1 and dec_valid=0 for 2 cycles. First valid dec_instr is the instruction at 8'h40; a second jump in the first flush cycle retargets pc and restarts 2 flush cycles.
- With NRISC_HAZARD_EN: dec_instr=8'h48 (LOAD r2), instr_in=8'h08 (reads r2) -> one cycle with stall=1, dec_valid=0, pc held; then dec_instr=8'h08. Without the macro: no bubble.
- ex_busy high for 3 cycles with dec_instr=8'h21 -> stall=1, pc and dec_instr unchanged for 3 cycles, resume next cycle; jump during ex_busy wins (FLUSH entered).
- Reset asserted mid-FLUSH with pc=8'h40 -> pc=8'h00, flush=0, dec_valid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/nrisc_pipe_ctrl.sv
// Pipeline sequencer for the 8-bit nRisc core: owns the PC and fetch enable, feeds decode,
// and handles jump flush, execute back-pressure and (with NRISC_HAZARD_EN) load-use bubbles.
module nrisc_pipe_ctrl #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [2:0] LOAD_OP      = 3'b010
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] instr_in,
  input  logic       instr_valid,
  input  logic       jump,
  input  logic [7:0] jump_target,
  input  logic       ex_busy,
  output logic [7:0] pc,
  output logic       fetch_en,
  output logic [7:0] dec_instr,
  output logic       dec_valid,
  output logic       stall,
  output logic       flush
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_STALL  = 2'd1;
  localparam logic [1:0] S_BUBBLE = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] dec_instr_q, dec_instr_d;
  logic       dec_valid_q, dec_valid_d;
  logic       hazard;

`ifdef NRISC_HAZARD_EN
  // Load in decode writes a register the incoming instruction reads (reg_b is 2 bits wide).
  assign hazard = dec_valid_q && (dec_instr_q[7:5] == LOAD_OP) && instr_valid &&
                  ((instr_in[4:2] == dec_instr_q[4:2]) ||
                   ({1'b0, instr_in[1:0]} == dec_instr_q[4:2]));
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    dec_instr_d = dec_instr_q;
    dec_valid_d = dec_valid_q;

    if (jump) begin
      pc_d        = jump_target;
      dec_valid_d = 1'b0;
      cnt_d       = CNT_INIT;
      state_d     = S_FLUSH;
    end else if (state_q == S_FLUSH) begin
      dec_valid_d = 1'b0;
      if (cnt_q == 2'd0) begin
        state_d = ex_busy ? S_STALL : S_RUN;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (ex_busy) begin
      state_d = S_STALL;
    end else if (state_q == S_STALL) begin
      state_d = S_RUN;
    end else if ((state_q == S_RUN) && hazard) begin
      dec_valid_d = 1'b0;
      state_d     = S_BUBBLE;
    end else begin
      // RUN, or the closing edge of BUBBLE where the re-presented instruction is taken
      state_d = S_RUN;
      if (instr_valid) begin
        dec_instr_d = instr_in;
        dec_valid_d = 1'b1;
        pc_d        = pc_q + 8'd1;
      end else begin
        dec_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      cnt_q       <= 2'd0;
      pc_q        <= RESET_PC;
      dec_instr_q <= 8'h00;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      dec_instr_q <= dec_instr_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign pc        = pc_q;
  assign dec_instr = dec_instr_q;
  assign dec_valid = dec_valid_q;
  assign fetch_en  = (state_q == S_RUN);
  assign stall     = (state_q == S_STALL) || (state_q == S_BUBBLE);
  assign flush     = (state_q == S_FLUSH);

endmodule
